fib_datapath: RTL

//   Register-file/ALU datapath for the Fibonacci calculator. Sits directly downstream of the

---
 rtl/fib_pkg.sv | 22 ++
 rtl/fib_alu.sv | 41 ++++
 rtl/fib_datapath.sv | 139 +++++++++++++
 3 files changed

// File: rtl/fib_pkg.sv
// fib_pkg
//   Shared definitions for the Fibonacci calculator: opcode encodings driven
//   by the control FSM and register-file indices. Used by both the datapath
//   and the control FSM.
package fib_pkg;

  // Opcodes (3 bits). Codes 3'b010 and any unused codes behave as NOP.
  localparam logic [2:0] OP_NOP   = 3'b000;
  localparam logic [2:0] OP_SET   = 3'b001;
  localparam logic [2:0] OP_DEC   = 3'b011;
  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_CHECK = 3'b101;
  localparam logic [2:0] OP_ADD   = 3'b110;
  localparam logic [2:0] OP_COPY  = 3'b111;

  // Register indices. R0 is the count register; R1..R3 are working registers.
  localparam logic [1:0] R0 = 2'd0;
  localparam logic [1:0] R1 = 2'd1;
  localparam logic [1:0] R2 = 2'd2;
  localparam logic [1:0] R3 = 2'd3;

endpackage

// File: rtl/fib_alu.sv
// fib_alu
//   Combinational arithmetic for the Fibonacci datapath.
//   Ports:
//     a, b      in   DW  operands for ADD
//     cnt       in   CW  current count (R0)
//     sum       out  DW  a + b modulo 2^DW
//     carry     out  1   carry out of bit DW-1 (only with FIB_OVF_DETECT_EN)
//     dec       out  CW  cnt - 1, saturating at 0
//     cnt_zero  out  1   cnt == 0
//     dec_zero  out  1   post-decrement count == 0 (cnt <= 1)
//   Configuration: FIB_OVF_DETECT_EN adds the carry output; without it no
//   carry logic exists.
module fib_alu #(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic [CW-1:0] cnt,
`ifdef FIB_OVF_DETECT_EN
  output logic          carry,
`endif
  output logic [DW-1:0] sum,
  output logic [CW-1:0] dec,
  output logic          cnt_zero,
  output logic          dec_zero
);

`ifdef FIB_OVF_DETECT_EN
  assign {carry, sum} = {1'b0, a} + {1'b0, b};
`else
  assign sum = a + b;
`endif

  assign cnt_zero = (cnt == '0);
  // Saturating decrement: a count of zero stays at zero.
  assign dec      = cnt_zero ? cnt : cnt - CW'(1);
  // Flag the post-decrement value so the FSM branches on the new count.
  assign dec_zero = (cnt <= CW'(1));

endmodule

// File: rtl/fib_datapath.sv
// fib_datapath
//   Register file (R0 count, R1..R3 working) and write decode for the
//   Fibonacci calculator. Executes one opcode per cycle with no stall.
//   Ports:
//     clk        in   1   clock, all state on posedge
//     rst        in   1   asynchronous active-high reset
//     opcode     in   3   operation (see fib_pkg)
//     op1        in   2   destination register index
//     op2        in   2   source register index
//     count_in   in   CW  n, sampled on LOAD
//     zero_flag  out  1   count status (combinational)
//     result     out  DW  R2, holds F(n) at the end of a sequence
//     ovf        out  1   sticky ADD overflow
//   Configuration: FIB_OVF_DETECT_EN enables the sticky overflow flop
//   (cleared by LOAD or rst); otherwise ovf is tied to 0.
module fib_datapath
  import fib_pkg::*;
#(
  parameter int DW = 16,
  parameter int CW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [2:0]    opcode,
  input  logic [1:0]    op1,
  input  logic [1:0]    op2,
  input  logic [CW-1:0] count_in,
  output logic          zero_flag,
  output logic [DW-1:0] result,
  output logic          ovf
);

  logic [CW-1:0] r0;
  logic [DW-1:0] r1, r2, r3;

  logic [DW-1:0] src_a, src_b;
  logic [DW-1:0] alu_sum;
  logic [CW-1:0] alu_dec;
  logic          cnt_zero, dec_zero;
  logic          wr_en;
  logic [DW-1:0] wr_data;

  // Register reads; R0 is zero-extended or truncated to DW.
  always_comb begin
    src_a = '0;
    case (op1)
      R0:      src_a = DW'(r0);
      R1:      src_a = r1;
      R2:      src_a = r2;
      default: src_a = r3;
    endcase
  end

  always_comb begin
    src_b = '0;
    case (op2)
      R0:      src_b = DW'(r0);
      R1:      src_b = r1;
      R2:      src_b = r2;
      default: src_b = r3;
    endcase
  end

`ifdef FIB_OVF_DETECT_EN
  logic alu_carry;
`endif

  fib_alu #(.DW(DW), .CW(CW)) u_alu (
    .a        (src_a),
    .b        (src_b),
    .cnt      (r0),
`ifdef FIB_OVF_DETECT_EN
    .carry    (alu_carry),
`endif
    .sum      (alu_sum),
    .dec      (alu_dec),
    .cnt_zero (cnt_zero),
    .dec_zero (dec_zero)
  );

  assign zero_flag = (opcode == OP_DEC) ? dec_zero : cnt_zero;
  assign result    = r2;

  // Generic register write: SET, ADD and COPY all target R[op1].
  always_comb begin
    wr_en   = 1'b0;
    wr_data = '0;
    case (opcode)
      OP_SET: begin
        wr_en   = 1'b1;
        wr_data = (op1 == R1) ? DW'(1) : '0;
      end
      OP_ADD: begin
        wr_en   = 1'b1;
        wr_data = alu_sum;
      end
      OP_COPY: begin
        wr_en   = 1'b1;
        wr_data = src_b;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0 <= '0;
      r1 <= '0;
      r2 <= '0;
      r3 <= '0;
    end else begin
      if (opcode == OP_LOAD) begin
        r0 <= count_in;
      end else if (opcode == OP_DEC) begin
        r0 <= alu_dec;
      end else if (wr_en && op1 == R0) begin
        r0 <= CW'(wr_data);
      end
      if (wr_en && op1 == R1) r1 <= wr_data;
      if (wr_en && op1 == R2) r2 <= wr_data;
      if (wr_en && op1 == R3) r3 <= wr_data;
    end
  end

`ifdef FIB_OVF_DETECT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf <= 1'b0;
    end else if (opcode == OP_LOAD) begin
      ovf <= 1'b0;
    end else if (opcode == OP_ADD && alu_carry) begin
      ovf <= 1'b1;
    end
  end
`else
  assign ovf = 1'b0;
`endif

endmodule
